pattern_detector_cfg: RTL and testbench
=======================================

// Module: pattern_detector_cfg
// PURPOSE
//  Parametrised serial bit-pattern detector, successor to the fixed-pattern Moore detector.
//  Pattern and length (1..MAX_LEN) are runtime-loadable; overlap/non-overlap mode is selectable.
//  A saturating match counter is included. Sits on a valid-qualified 1-bit serial stream.
//  pattern_o is Moore-registered.
// PARAMETERS
//  MAX_LEN      8           longest supported pattern, in bits (>=2)
//  DEFAULT_PAT  8'b00001011 reset pattern; LSB-aligned, low DEFAULT_LEN bits used
//  DEFAULT_LEN  4           reset pattern length
//  DEFAULT_OVL  1           reset mode: 1 = overlapping, 0 = non-overlapping
//  CNT_W        16          match counter width
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          asynchronous, active-high reset
//  valid_i      in   1          d_i accepted on rising edge when high
//  d_i          in   1          serial data bit
//  cfg_load_i   in   1          load cfg_pat_i/cfg_len_i/cfg_ovl_i this edge
//  cfg_pat_i    in   MAX_LEN    new pattern; bit [len-1] is the first bit received
//  cfg_len_i    in   LEN_W      new length; LEN_W = $clog2(MAX_LEN+1)
//  cfg_ovl_i    in   1          new overlap mode
//  cnt_clr_i    in   1          synchronous clear of match_cnt_o
//  pattern_o    out  1          high while last accepted bits complete a match
//  match_cnt_o  out  CNT_W      number of matches, saturating
// BEHAVIOUR
//  Reset values:
//   - hist=0, fill=0, pattern_o=0, match_cnt_o=0
//   - pat/len/ovl = DEFAULT_PAT/DEFAULT_LEN/DEFAULT_OVL
//  Accept (valid_i=1, cfg_load_i=0):
//   - hist <= {hist[MAX_LEN-2:0], d_i}
//   - fill <= min(fill+1, MAX_LEN)
//  Match condition, evaluated on the next hist/fill values:
//   - fill_next >= len AND hist_next[len-1:0] == pat[len-1:0]
//  pattern_o is registered:
//   - Goes high the edge that accepts the completing bit; visible in the following cycle.
//   - Holds its value while valid_i=0.
//   - Updated only on an accepted bit or on a load.
//  States: FILL (fill<len), HUNT (fill>=len, no match), MATCH (pattern_o=1).
//   - Overlap mode: MATCH -> MATCH/HUNT on the next bit; fill continues.
//   - Non-overlap mode: a match forces fill <= 0, so the next match needs len fresh bits.
//  cfg_load_i:
//   - Priority over valid_i; a bit presented in the same cycle is dropped.
//   - Latches pat/len/ovl; clears fill, hist and pattern_o; does not clear match_cnt_o.
//  cfg_len_i == 0 or > MAX_LEN:
//   - len is clamped (0 -> 1, >MAX_LEN -> MAX_LEN); pattern is still loaded.
//  Counter:
//   - +1 on each match edge; saturates at 2^CNT_W-1, never wraps.
//   - cnt_clr_i alone -> 0.
//   - cnt_clr_i together with a match -> 1.
//  Reset mid-stream: all state returns to reset values immediately (asynchronous).
//   - Partial matches are discarded.
//  Latency: 1 cycle from the accepting edge to pattern_o / match_cnt_o update.
// STRUCTURE
//  Include pattern_det_defs.vh:
//   - LEN_W computation
//   - mask function mask(len) = (1<<len)-1
//   - state encodings FILL/HUNT/MATCH
//  Sub-module sat_counter #(CNT_W) with inc/clr inputs; the rest stays flat.
// TESTING
//  1. Reset, default 1011 overlap, stream 1,0,1,1,0,1,1 -> pattern_o high after bits 4 and 7; count=2.
//  2. Load pat=101 len=3 ovl=0, stream 1,0,1,0,1 -> one match (bit 3); in ovl=1 -> matches at bits 3,5.
//  3. Stream 1011 with valid_i low for 3 cycles between bits -> single match; pattern_o holds 1 through idle cycles.
//  4. Load mid-pattern (after 1,0,1) with valid_i=1 -> bit dropped, pattern_o=0, fill=0; no spurious match.
//  5. CNT_W=2, 5 matches -> match_cnt_o sticks at 3; cnt_clr_i with a match edge -> 1.
//  6. Assert rst_i between clock edges right after a match -> pattern_o and match_cnt_o go to 0 immediately; default pattern restored.

Source files
------------

// File: rtl/pattern_detector_cfg_pkg.sv
// Shared types and helpers for the runtime-configurable serial pattern detector.
package pattern_detector_cfg_pkg;

  // Detector FSM encodings: filling history, hunting for a match, match reported.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_MATCH = 2'd2
  } state_e;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pattern_detector_cfg_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an increment yields 1.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_cfg.sv
// Runtime-loadable serial bit-pattern detector with overlap selection and a saturating
// match counter. pattern_o is a Moore output registered from the MATCH state.
module pattern_detector_cfg
  import pattern_detector_cfg_pkg::*;
#(
  parameter int unsigned       MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'('b1011),
  parameter int unsigned       DEFAULT_LEN = 4,
  parameter bit                DEFAULT_OVL = 1'b1,
  parameter int unsigned       CNT_W       = 16,
  localparam int unsigned      LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               d_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_ovl_i,
  input  logic               cnt_clr_i,
  output logic               pattern_o,
  output logic [CNT_W-1:0]   match_cnt_o
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               pattern_d;

  logic [MAX_LEN-1:0] hist_shift_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic [MAX_LEN-1:0] len_mask_c;
  logic               hit_c;
  logic               match_c;

  // Low-len-bits mask, i.e. (1 << len) - 1 without a variable shift.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

  // Out-of-range lengths are clamped into 1..MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return LEN_W'(1);
    end else if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return len;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= DEFAULT_PAT;
      len_q     <= LEN_W'(DEFAULT_LEN);
      ovl_q     <= DEFAULT_OVL;
      pattern_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      pattern_o <= pattern_d;
    end
  end

  // Candidate history/fill if the current bit is accepted, and whether that completes a match.
  always_comb begin
    hist_shift_c = {hist_q[MAX_LEN-2:0], d_i};
    fill_inc_c   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    len_mask_c   = len_mask(len_q);
    hit_c        = (fill_inc_c >= len_q) &&
                   ((hist_shift_c & len_mask_c) == (pat_q & len_mask_c));
  end

  // Next-state: a load wins over data; idle cycles hold everything.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    match_c   = 1'b0;
    pattern_d = 1'b0;

    if (cfg_load_i) begin
      pat_d   = cfg_pat_i;
      len_d   = clamp_len(cfg_len_i);
      ovl_d   = cfg_ovl_i;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (valid_i) begin
      hist_d = hist_shift_c;
      if (hit_c) begin
        match_c = 1'b1;
        state_d = ST_MATCH;
        // Non-overlapping mode demands len fresh bits before the next match.
        fill_d  = ovl_q ? fill_inc_c : '0;
      end else begin
        fill_d  = fill_inc_c;
        state_d = (fill_inc_c < len_q) ? ST_FILL : ST_HUNT;
      end
    end

    pattern_d = (state_d == ST_MATCH);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (match_c),
    .clr_i (cnt_clr_i),
    .cnt_o (match_cnt_o)
  );

endmodule

// File: tb/tb_pattern_detector_cfg.sv
// Scoreboard bench for pattern_detector_cfg: a wide-counter and a 2-bit-counter instance share stimulus.
module tb_pattern_detector_cfg;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i, d_i, cfg_load_i, cfg_ovl_i, cnt_clr_i;
  logic [MAX_LEN-1:0] cfg_pat_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               pattern_o, pattern_s;
  logic [15:0]        cnt_o;
  logic [1:0]         cnt_s;

  always #5 clk_i = ~clk_i;

  pattern_detector_cfg dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .d_i(d_i),
    .cfg_load_i(cfg_load_i), .cfg_pat_i(cfg_pat_i), .cfg_len_i(cfg_len_i),
    .cfg_ovl_i(cfg_ovl_i), .cnt_clr_i(cnt_clr_i),
    .pattern_o(pattern_o), .match_cnt_o(cnt_o)
  );

  pattern_detector_cfg #(.CNT_W(2)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .d_i(d_i),
    .cfg_load_i(cfg_load_i), .cfg_pat_i(cfg_pat_i), .cfg_len_i(cfg_len_i),
    .cfg_ovl_i(cfg_ovl_i), .cnt_clr_i(cnt_clr_i),
    .pattern_o(pattern_s), .match_cnt_o(cnt_s)
  );

  typedef struct {
    logic        pout;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_hist, m_fill, m_pat, m_len, m_cnt, m_cnt_s;
  bit m_ovl, m_pout;

  task automatic model_reset();
    m_hist = 0; m_fill = 0; m_pat = 'b1011; m_len = 4; m_ovl = 1'b1;
    m_pout = 1'b0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // Drive one cycle, advance the model, push the expectation, wait until #1 after the edge.
  task automatic send(input bit v, input bit d, input bit ld, input int cpat,
                      input int clen, input bit covl, input bit clr);
    bit   m;
    int   msk;
    exp_t x;
    @(negedge clk_i);
    valid_i = v; d_i = d; cfg_load_i = ld; cfg_pat_i = MAX_LEN'(cpat);
    cfg_len_i = LEN_W'(clen); cfg_ovl_i = covl; cnt_clr_i = clr;
    m = 1'b0;
    if (ld) begin
      m_pat = cpat & 8'hFF;
      m_len = (clen == 0) ? 1 : (clen > MAX_LEN) ? MAX_LEN : clen;
      m_ovl = covl; m_hist = 0; m_fill = 0; m_pout = 1'b0;
    end else if (v) begin
      m_hist = ((m_hist << 1) | int'(d)) & 8'hFF;
      m_fill = (m_fill + 1 > MAX_LEN) ? MAX_LEN : m_fill + 1;
      msk    = (1 << m_len) - 1;
      m      = (m_fill >= m_len) && ((m_hist & msk) == (m_pat & msk));
      m_pout = m;
      if (m && !m_ovl) m_fill = 0;
    end
    if (clr) begin
      m_cnt   = m ? 1 : 0;
      m_cnt_s = m ? 1 : 0;
    end else if (m) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    x.pout = m_pout; x.cnt = 16'(m_cnt); x.cnt_s = 2'(m_cnt_s);
    sb.push_back(x);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; cfg_load_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b0; d_i = 1'b0; cfg_load_i = 1'b0; cfg_pat_i = '0;
    cfg_len_i = '0; cfg_ovl_i = 1'b0; cnt_clr_i = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({pattern_o, cnt_o, pattern_s, cnt_s} !== 20'd0) begin
      errors++;
      $display("FAIL reset: pattern=%b cnt=%0d pattern_s=%b cnt_s=%0d, required all 0",
               pattern_o, cnt_o, pattern_s, cnt_s);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_default_overlap();
    bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    foreach (bits[i]) begin
      send(1'b1, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({pattern_o, cnt_o, cnt_s} !== {e.pout, e.cnt, e.cnt_s}) begin
        errors++;
        $display("FAIL default_overlap bit%0d: got p=%b c=%0d cs=%0d, required p=%b c=%0d cs=%0d",
                 i + 1, pattern_o, cnt_o, cnt_s, e.pout, e.cnt, e.cnt_s);
      end
    end
    checks++;
    if (cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL default_overlap_count: got %0d, required 2", cnt_o);
    end
  endtask

  task automatic test_overlap_modes();
    bit bits[5] = '{1, 0, 1, 0, 1};
    for (int mode = 0; mode < 2; mode++) begin
      send(1'b0, 1'b0, 1'b1, 'b101, 3, bit'(mode), 1'b1);
      e = sb.pop_front();
      foreach (bits[i]) begin
        send(1'b1, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
          errors++;
          $display("FAIL ovl%0d bit%0d: got p=%b c=%0d, required p=%b c=%0d",
                   mode, i + 1, pattern_o, cnt_o, e.pout, e.cnt);
        end
      end
      checks++;
      if (cnt_o !== 16'(mode + 1)) begin
        errors++;
        $display("FAIL ovl%0d_count: got %0d, required %0d", mode, cnt_o, mode + 1);
      end
    end
  endtask

  task automatic test_idle_gaps();
    bit bits[4] = '{1, 0, 1, 1};
    send(1'b0, 1'b0, 1'b1, 'b1011, 4, 1'b1, 1'b1);
    e = sb.pop_front();
    foreach (bits[i]) begin
      for (int k = 0; k < 4; k++) begin
        send(k == 0, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
          errors++;
          $display("FAIL idle_gap bit%0d cyc%0d: got p=%b c=%0d, required p=%b c=%0d",
                   i + 1, k, pattern_o, cnt_o, e.pout, e.cnt);
        end
      end
    end
  endtask

  task automatic test_load_mid_pattern();
    bit bits[4] = '{1, 0, 1, 1};
    send(1'b0, 1'b0, 1'b1, 'b1011, 4, 1'b1, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    // The load swallows the bit that would have completed 1011.
    send(1'b1, 1'b1, 1'b1, 'b1011, 4, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
      errors++;
      $display("FAIL load_drop: got p=%b c=%0d, required p=%b c=%0d",
               pattern_o, cnt_o, e.pout, e.cnt);
    end
    foreach (bits[i]) begin
      send(1'b1, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
        errors++;
        $display("FAIL load_refill bit%0d: got p=%b c=%0d, required p=%b c=%0d",
                 i + 1, pattern_o, cnt_o, e.pout, e.cnt);
      end
    end
  endtask

  task automatic test_len_clamp();
    bit bits[3] = '{1, 0, 1};
    send(1'b0, 1'b0, 1'b1, 'b1, 0, 1'b1, 1'b1);
    e = sb.pop_front();
    foreach (bits[i]) begin
      send(1'b1, bits[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
        errors++;
        $display("FAIL clamp_len0 bit%0d: got p=%b c=%0d, required p=%b c=%0d",
                 i + 1, pattern_o, cnt_o, e.pout, e.cnt);
      end
    end
    send(1'b0, 1'b0, 1'b1, 'hA5, 15, 1'b1, 1'b1);
    e = sb.pop_front();
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, bit'((8'hA5 >> i) & 1), 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
        errors++;
        $display("FAIL clamp_len15 bit%0d: got p=%b c=%0d, required p=%b c=%0d",
                 8 - i, pattern_o, cnt_o, e.pout, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    send(1'b0, 1'b0, 1'b1, 'b1, 1, 1'b1, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 7; i++) begin
      // i==5: clear with a match edge; i==6: clear alone on an idle cycle
      send(i != 6, 1'b1, 1'b0, 0, 0, 1'b0, i >= 5);
      e = sb.pop_front();
      checks++;
      if ({pattern_s, cnt_s, cnt_o} !== {e.pout, e.cnt_s, e.cnt}) begin
        errors++;
        $display("FAIL saturate step%0d: got p=%b cs=%0d c=%0d, required p=%b cs=%0d c=%0d",
                 i, pattern_s, cnt_s, cnt_o, e.pout, e.cnt_s, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    bit bits_a[3] = '{1, 1, 0};
    bit bits_b[4] = '{1, 0, 1, 1};
    send(1'b0, 1'b0, 1'b1, 'b110, 3, 1'b0, 1'b0);
    e = sb.pop_front();
    foreach (bits_a[i]) begin
      send(1'b1, bits_a[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    checks++;
    if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
      errors++;
      $display("FAIL pre_reset_match: got p=%b c=%0d, required p=%b c=%0d",
               pattern_o, cnt_o, e.pout, e.cnt);
    end
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({pattern_o, cnt_o, pattern_s, cnt_s} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got p=%b c=%0d ps=%b cs=%0d, required all 0",
               pattern_o, cnt_o, pattern_s, cnt_s);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    foreach (bits_b[i]) begin
      send(1'b1, bits_b[i], 1'b0, 0, 0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({pattern_o, cnt_o} !== {e.pout, e.cnt}) begin
        errors++;
        $display("FAIL default_restored bit%0d: got p=%b c=%0d, required p=%b c=%0d",
                 i + 1, pattern_o, cnt_o, e.pout, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_overlap_modes();
    test_idle_gaps();
    test_load_mid_pattern();
    test_len_clamp();
    test_saturation();
    test_reset_mid_stream();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
